// File: rtl/hps_cmd_regs.sv
// Command/status register block between the HPS lightweight bus and the
// neural-net master FSM: command strobes, result capture, busy cycles, watchdog.
module hps_cmd_regs #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
  parameter int unsigned RESULT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          address,
  input  logic                write,
  input  logic [31:0]         writedata,
  input  logic                read,
  output logic [31:0]         readdata,
  output logic                readdatavalid,
  input  logic                arm,
  input  logic                result_valid,
  input  logic [RESULT_W-1:0] result,
  output logic [1:0]          command,
  output logic                training,
  output logic                stop,
  output logic                interrupt
);

  logic                done_q;
  logic                err_q;
  logic                timeout_q;
  logic [RESULT_W-1:0] result_q;
  logic [31:0]         cycles_q;
  logic [31:0]         wd_cnt;

  logic        ctrl_wr;
  logic        abort;
  logic        start_req;
  logic        start_ok;
  logic        start_busy;
  logic        status_rd;
  logic        result_rd;
  logic        wd_hit;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:5];

  // Abort suppresses every effect of the cmd field in the same write.
  assign ctrl_wr    = write && (address == 2'd0);
  assign abort      = ctrl_wr && writedata[4];
  assign start_req  = ctrl_wr && !writedata[4] && (writedata[1:0] == 2'b10);
  assign start_ok   = start_req && !arm;
  assign start_busy = start_req && arm;
  assign status_rd  = read && (address == 2'd1);
  assign result_rd  = read && (address == 2'd2);

  // Fires on the edge that samples the TIMEOUT_CYCLES-th consecutive arm cycle.
  assign wd_hit = (TIMEOUT_CYCLES != 32'd0) && arm &&
                  (wd_cnt == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0: rd_mux[2] = training;
      2'd1: rd_mux[4:0] = {training, timeout_q, err_q, done_q, arm};
      2'd2: rd_mux[RESULT_W-1:0] = result_q;
      default: rd_mux = cycles_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      command       <= 2'b00;
      training      <= 1'b0;
      stop          <= 1'b0;
      interrupt     <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      timeout_q     <= 1'b0;
      result_q      <= '0;
      cycles_q      <= '0;
      wd_cnt        <= '0;
    end else begin
      readdatavalid <= read;
      readdata      <= read ? rd_mux : '0;

      command   <= (ctrl_wr && !writedata[4] && !start_busy) ? writedata[1:0] : 2'b00;
      stop      <= ctrl_wr && writedata[3] && training && arm;
      interrupt <= abort || wd_hit;
      if (ctrl_wr)
        training <= writedata[2];

      // Set events win over clear-on-read in the same cycle.
      if (start_ok)
        done_q <= 1'b0;
      else if (result_valid)
        done_q <= 1'b1;
      else if (result_rd)
        done_q <= 1'b0;

      if (start_busy)
        err_q <= 1'b1;
      else if (start_ok || status_rd)
        err_q <= 1'b0;

      if (wd_hit)
        timeout_q <= 1'b1;
      else if (status_rd)
        timeout_q <= 1'b0;

      if (result_valid)
        result_q <= result;

      if (start_ok)
        cycles_q <= '0;
      else if (arm && (cycles_q != '1))
        cycles_q <= cycles_q + 32'd1;

      if (!arm || wd_hit || (TIMEOUT_CYCLES == 32'd0))
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hps_cmd_regs.sv
// Directed self-checking bench for hps_cmd_regs with a 16-cycle watchdog.
module tb_hps_cmd_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        arm = 1'b0;
  logic        result_valid = 1'b0;
  logic [7:0]  result = '0;
  logic [1:0]  command;
  logic        training;
  logic        stop;
  logic        interrupt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  hps_cmd_regs #(.TIMEOUT_CYCLES(32'd16), .RESULT_W(8)) dut (
    .clk(clk), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata),
    .readdatavalid(readdatavalid), .arm(arm), .result_valid(result_valid),
    .result(result), .command(command), .training(training), .stop(stop),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
    chk({tag, "_valid"}, {31'd0, readdatavalid}, 32'd1);
    chk(tag, readdata, exp);
  endtask

  initial begin
    // Reset
    tick(); tick();
    reset = 1'b0;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_rdvalid", {31'd0, readdatavalid}, 32'd0);
    chk("rst_command", {30'd0, command}, 32'd0);
    chk("rst_training", {31'd0, training}, 32'd0);
    chk("rst_stop", {31'd0, stop}, 32'd0);
    chk("rst_interrupt", {31'd0, interrupt}, 32'd0);
    rd("rst_cycles", 2'd3, 32'd0);
    rd("rst_status", 2'd1, 32'd0);
    tick();
    chk("rdvalid_idle", {31'd0, readdatavalid}, 32'd0);

    // Start accepted
    wr(2'd0, 32'h2);
    chk("start_cmd", {30'd0, command}, 32'd2);
    tick();
    chk("start_cmd_low", {30'd0, command}, 32'd0);
    rd("start_status", 2'd1, 32'h0);

    // Busy rejection
    arm = 1'b1;
    wr(2'd0, 32'h2);
    chk("busy_cmd", {30'd0, command}, 32'd0);
    rd("busy_status1", 2'd1, 32'h5);
    rd("busy_status2", 2'd1, 32'h1);
    arm = 1'b0;

    // Training stop
    wr(2'd0, 32'h4);
    chk("train_level", {31'd0, training}, 32'd1);
    rd("ctrl_readback", 2'd0, 32'h4);
    arm = 1'b1;
    wr(2'd0, 32'hC);
    chk("stop_pulse", {31'd0, stop}, 32'd1);
    tick();
    chk("stop_low", {31'd0, stop}, 32'd0);
    wr(2'd0, 32'h0);
    wr(2'd0, 32'h8);
    chk("stop_untrained", {31'd0, stop}, 32'd0);
    arm = 1'b0;

    // Result capture after 37 arm cycles (watchdog fires twice meanwhile)
    wr(2'd0, 32'h2);
    chk("start2_cmd", {30'd0, command}, 32'd2);
    arm = 1'b1;
    repeat (37) tick();
    arm = 1'b0;
    result = 8'h2A; result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    rd("res_status_done", 2'd1, 32'h0A);
    rd("res_result", 2'd2, 32'h2A);
    rd("res_status_clr", 2'd1, 32'h0);
    rd("res_cycles", 2'd3, 32'd37);
    rd("res_cycles_hold", 2'd3, 32'd37);

    // Watchdog
    arm = 1'b1;
    repeat (15) tick();
    chk("wd_before", {31'd0, interrupt}, 32'd0);
    tick();
    chk("wd_pulse", {31'd0, interrupt}, 32'd1);
    tick();
    chk("wd_low", {31'd0, interrupt}, 32'd0);
    arm = 1'b0;
    rd("wd_status", 2'd1, 32'h08);

    // Abort has priority over cmd
    wr(2'd0, 32'h12);
    chk("abort_int", {31'd0, interrupt}, 32'd1);
    chk("abort_cmd", {30'd0, command}, 32'd0);
    tick();
    chk("abort_low", {31'd0, interrupt}, 32'd0);

    // Ignored write to a read-only address
    wr(2'd2, 32'hFF);
    rd("ro_result", 2'd2, 32'h2A);

    // Simultaneous read and write: read sees pre-write CTRL
    address = 2'd0; writedata = 32'h4; write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    chk("rw_old", readdata, 32'h0);
    chk("rw_train", {31'd0, training}, 32'd1);
    rd("rw_new", 2'd0, 32'h4);

    // result_valid coincident with RESULT read
    result = 8'h55; result_valid = 1'b1;
    rd("coinc_old", 2'd2, 32'h2A);
    result_valid = 1'b0;
    rd("coinc_status", 2'd1, 32'h12);
    rd("coinc_new", 2'd2, 32'h55);

    // Reset mid-run
    arm = 1'b1;
    wr(2'd0, 32'hC);
    chk("run_stop", {31'd0, stop}, 32'd1);
    reset = 1'b1;
    address = 2'd0; writedata = 32'h1E; write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    chk("mid_rst_outs", {readdata[3:0], readdatavalid, command, training, stop, interrupt}, 32'd0);
    reset = 1'b0;
    arm = 1'b0;
    rd("mid_rst_cycles", 2'd3, 32'd0);
    rd("mid_rst_status", 2'd1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1, "bench time limit");
  end

endmodule
